// File: rtl/mips_trace_monitor.sv
// rtl/mips_trace_monitor.sv - MIPS execution trace monitor with circular buffer; `define TRACE_DM_EN to capture data-memory writes
module mips_trace_monitor #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int MAX_CYCLES  = 600,
    parameter int STALL_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              rf_we,
    input  logic [4:0]        rf_waddr,
    input  logic [DATA_W-1:0] rf_wdata,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [1:0]        rd_kind,
    output logic [15:0]       rd_cycle,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [15:0]       cycle_count,
    output logic              done,
    output logic [1:0]        done_cause,
    output logic              overflow,
    output logic [7:0]        ovf_count
);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int PTR_W   = IDX_W + 1;
    localparam int STALL_W = $clog2(STALL_LIMIT) + 1;

    typedef enum logic [1:0] {S_RUN, S_MARK, S_DRAIN, S_DONE} state_t;

    state_t              state_q;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic [15:0]         cycle_q;
    logic [1:0]          cause_q;
    logic                ovf_q;
    logic [7:0]          ovf_cnt_q, ovf_cnt_d;

    logic [1:0]          kind_mem  [DEPTH];
    logic [15:0]         cycle_mem [DEPTH];
    logic [ADDR_W-1:0]   addr_mem  [DEPTH];
    logic [DATA_W-1:0]   data_mem  [DEPTH];

    logic [PTR_W-1:0]    count;
    logic [PTR_W:0]      avail;
    logic                pop, run, rf_ev, dm_ev;
    logic                want0, want1, push0, push1;
    logic [1:0]          n_drop;
    logic                hit_stall, hit_cycle;
    logic [1:0]          e0_kind;
    logic [ADDR_W-1:0]   e0_addr;
    logic [DATA_W-1:0]   e0_data;
    logic [IDX_W-1:0]    wr_idx0, wr_idx1, rd_idx;
    logic [8:0]          ovf_sum;

    assign run = (state_q == S_RUN);
    assign rf_ev = run && rf_we && (rf_waddr != 5'd0);
`ifdef TRACE_DM_EN
    assign dm_ev = run && dm_we;
`else
    logic unused_dm_we;
    assign unused_dm_we = dm_we;
    assign dm_ev = 1'b0;
`endif

    assign count    = wr_ptr_q - rd_ptr_q;
    assign rd_valid = (count != '0);
    assign pop      = rd_valid && rd_ready;
    // A pop in the same cycle frees a slot, so pushes into a full buffer still land.
    assign avail    = (PTR_W+1)'(DEPTH) - {1'b0, count} + {{PTR_W{1'b0}}, pop};

    assign rd_idx   = rd_ptr_q[IDX_W-1:0];
    assign wr_idx0  = wr_ptr_q[IDX_W-1:0];
    assign wr_idx1  = wr_idx0 + IDX_W'(1);
    assign rd_kind  = kind_mem[rd_idx];
    assign rd_cycle = cycle_mem[rd_idx];
    assign rd_addr  = addr_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

    assign cycle_count = cycle_q;
    assign done        = (state_q == S_DONE);
    assign done_cause  = cause_q;
    assign overflow    = ovf_q;
    assign ovf_count   = ovf_cnt_q;

    // Stall counter and termination conditions evaluated on the current cycle's PC.
    always_comb begin
        stall_d   = (pc_in == pc_q) ? stall_q + STALL_W'(1) : '0;
        hit_stall = run && (stall_d == STALL_W'(STALL_LIMIT - 1));
        hit_cycle = run && (cycle_q == 16'(MAX_CYCLES - 1));
    end

    // Select the first-slot entry (marker, RF or DM) and decide how many pushes fit.
    always_comb begin
        e0_kind = 2'b01;
        e0_addr = ADDR_W'(rf_waddr);
        e0_data = rf_wdata;
        if (state_q == S_MARK) begin
            e0_kind = 2'b11;
            e0_addr = pc_q;
            e0_data = DATA_W'(cause_q);
        end else if (!rf_ev) begin
            e0_kind = 2'b10;
            e0_addr = dm_addr;
            e0_data = dm_wdata;
        end
        want0   = rf_ev || dm_ev || (state_q == S_MARK);
        want1   = rf_ev && dm_ev;
        push0   = want0 && (avail != '0);
        push1   = want1 && (avail >= (PTR_W+1)'(2));
        n_drop  = 2'(want0 && !push0) + 2'(want1 && !push1);
        ovf_sum = {1'b0, ovf_cnt_q} + 9'(n_drop);
        ovf_cnt_d = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
    end

    // Trace storage; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push0) begin
            kind_mem[wr_idx0]  <= e0_kind;
            cycle_mem[wr_idx0] <= cycle_q;
            addr_mem[wr_idx0]  <= e0_addr;
            data_mem[wr_idx0]  <= e0_data;
        end
        if (push1) begin
            kind_mem[wr_idx1]  <= 2'b10;
            cycle_mem[wr_idx1] <= cycle_q;
            addr_mem[wr_idx1]  <= dm_addr;
            data_mem[wr_idx1]  <= dm_wdata;
        end
    end

    // Run/mark/drain/done sequencing, pointers, counters and overflow bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_RUN;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pc_q      <= '0;
            stall_q   <= '0;
            cycle_q   <= '0;
            cause_q   <= 2'b00;
            ovf_q     <= 1'b0;
            ovf_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(push0) + PTR_W'(push1);
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
            if (n_drop != 2'd0) begin
                ovf_q     <= 1'b1;
                ovf_cnt_q <= ovf_cnt_d;
            end
            case (state_q)
                S_RUN: begin
                    pc_q    <= pc_in;
                    stall_q <= stall_d;
                    if (hit_stall || hit_cycle) begin
                        cause_q <= {hit_stall, hit_cycle};
                        state_q <= S_MARK;
                    end else begin
                        cycle_q <= cycle_q + 16'd1;
                    end
                end
                S_MARK: begin
                    if (push0) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if ((count == '0) || ((count == PTR_W'(1)) && pop)) state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                default: state_q <= S_RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_trace_monitor.sv
// tb/tb_mips_trace_monitor.sv - scoreboard bench for mips_trace_monitor
module tb_mips_trace_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_in = 32'h100;
    logic        rf_we = 1'b0;
    logic [4:0]  rf_waddr = 5'd0;
    logic [31:0] rf_wdata = 32'd0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = 32'd0;
    logic [31:0] dm_wdata = 32'd0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [1:0]  rd_kind;
    logic [15:0] rd_cycle;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic [15:0] cycle_count;
    logic        done;
    logic [1:0]  done_cause;
    logic        overflow;
    logic [7:0]  ovf_count;

    always #5 clk = ~clk;

    mips_trace_monitor #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(4), .MAX_CYCLES(20), .STALL_LIMIT(8)
    ) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_kind(rd_kind),
        .rd_cycle(rd_cycle), .rd_addr(rd_addr), .rd_data(rd_data),
        .cycle_count(cycle_count), .done(done), .done_cause(done_cause),
        .overflow(overflow), .ovf_count(ovf_count)
    );

    typedef struct {
        logic [1:0]  kind;
        logic [15:0] cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    ent_t exp_q[$];
    ent_t mon_e;
    int   total = 0;
    int   bad = 0;
    logic pc_hold = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [1:0] k, input logic [15:0] c,
                            input logic [31:0] a, input logic [31:0] d);
        ent_t e;
        e.kind = k; e.cyc = c; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted head entry is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_entry actual kind=%0d cycle=%0d addr=0x%0h data=0x%0h required=none",
                         rd_kind, rd_cycle, rd_addr, rd_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("entry_kind",  32'(rd_kind),  32'(mon_e.kind));
                chk("entry_cycle", 32'(rd_cycle), 32'(mon_e.cyc));
                chk("entry_addr",  rd_addr,       mon_e.addr);
                chk("entry_data",  rd_data,       mon_e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (!pc_hold) pc_in = pc_in + 32'd4;
    endtask

    task automatic hold_reset();
        rst = 1'b0;
        rf_we = 1'b0; rf_waddr = 5'd0; rf_wdata = 32'd0;
        dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0;
        rd_ready = 1'b0; pc_hold = 1'b0; pc_in = 32'h100;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    // After this returns, the inputs currently driven are sampled in cycle 0.
    task automatic release_reset();
        rst = 1'b1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rd_valid"},    32'(rd_valid),    32'd0);
        chk({tag, "_cycle_count"}, 32'(cycle_count), 32'd0);
        chk({tag, "_done"},        32'(done),        32'd0);
        chk({tag, "_done_cause"},  32'(done_cause),  32'd0);
        chk({tag, "_overflow"},    32'(overflow),    32'd0);
        chk({tag, "_ovf_count"},   32'(ovf_count),   32'd0);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_done_reached"}, 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single RF write and R0 filtering.
        hold_reset();
        check_reset("por");
        release_reset();
        rd_ready = 1'b1;
        step();
        step();
        rf_we = 1'b1; rf_waddr = 5'd0; rf_wdata = 32'h99;
        step();
        chk("r0_ignored", 32'(rd_valid), 32'd0);
        rf_waddr = 5'd8; rf_wdata = 32'h5;
        push_exp(2'b01, 16'd3, 32'd8, 32'h5);
        step();
        chk("rf_latency_valid", 32'(rd_valid), 32'd1);
        rf_we = 1'b0;
        step();
        chk("rf_popped", 32'(rd_valid), 32'd0);
        chk("cycle_count_c5", 32'(cycle_count), 32'd5);
        chk("s1_queue_empty", 32'(exp_q.size()), 32'd0);

        // Simultaneous RF and DM write.
        hold_reset();
        release_reset();
        rd_ready = 1'b1;
        repeat (5) step();
        rf_we = 1'b1; rf_waddr = 5'd9; rf_wdata = 32'h11;
        dm_we = 1'b1; dm_addr = 32'h14; dm_wdata = 32'h22;
        push_exp(2'b01, 16'd5, 32'd9, 32'h11);
`ifdef TRACE_DM_EN
        push_exp(2'b10, 16'd5, 32'h14, 32'h22);
`endif
        step();
        rf_we = 1'b0; dm_we = 1'b0;
        chk("dual_valid", 32'(rd_valid), 32'd1);
        repeat (3) step();
        chk("dual_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("dual_drained", 32'(rd_valid), 32'd0);

        // Overflow with DEPTH=4 and a stalled consumer.
        hold_reset();
        release_reset();
        for (int i = 0; i < 6; i++) begin
            rf_we = 1'b1; rf_waddr = 5'(i + 1); rf_wdata = 32'h100 + 32'(i);
            if (i < 4) push_exp(2'b01, 16'(i), 32'(i + 1), 32'h100 + 32'(i));
            step();
        end
        rf_we = 1'b0;
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(ovf_count), 32'd2);
        chk("ovf_valid", 32'(rd_valid), 32'd1);
        rd_ready = 1'b1;
        repeat (6) step();
        chk("ovf_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("ovf_drained", 32'(rd_valid), 32'd0);

        // Cycle-limit termination.
        hold_reset();
        release_reset();
        rd_ready = 1'b1;
        push_exp(2'b11, 16'd19, 32'h100 + 32'd76, 32'd1);
        repeat (20) step();
        chk("limit_count_frozen", 32'(cycle_count), 32'd19);
        chk("limit_not_done_yet", 32'(done), 32'd0);
        wait_done("limit", 20);
        chk("limit_cause", 32'(done_cause), 32'd1);
        chk("limit_count_final", 32'(cycle_count), 32'd19);
        chk("limit_queue_empty", 32'(exp_q.size()), 32'd0);

        // PC self-loop termination.
        hold_reset();
        release_reset();
        rd_ready = 1'b1;
        repeat (10) step();
        pc_hold = 1'b1; pc_in = 32'h40;
        push_exp(2'b11, 16'd17, 32'h40, 32'd2);
        wait_done("stall", 30);
        chk("stall_cause", 32'(done_cause), 32'd2);
        chk("stall_count", 32'(cycle_count), 32'd17);
        chk("stall_queue_empty", 32'(exp_q.size()), 32'd0);

        // Mid-run reset in cycle 12 of a repeated stall run.
        hold_reset();
        release_reset();
        rd_ready = 1'b1;
        repeat (10) step();
        pc_hold = 1'b1; pc_in = 32'h40;
        repeat (2) step();
        rst = 1'b0;
        #1;
        check_reset("midrst");
        pc_hold = 1'b0; pc_in = 32'h200;
        @(posedge clk);
        #1;
        release_reset();
        step();
        rf_we = 1'b1; rf_waddr = 5'd3; rf_wdata = 32'h33;
        push_exp(2'b01, 16'd1, 32'd3, 32'h33);
        step();
        rf_we = 1'b0;
        chk("restart_valid", 32'(rd_valid), 32'd1);
        step();
        chk("restart_count", 32'(cycle_count), 32'd3);
        chk("restart_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("restart_not_done", 32'(done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_trace_monitor.md
# mips_trace_monitor

Synthesizable execution monitor for the pipelined MIPS core; the parametrised successor to the fixed 600-cycle print-every-cycle bench loop. It samples PC, register-file writeback and data-memory writes each cycle, timestamps them into a circular trace buffer, and drains them over a valid/ready port. It terminates the run on a cycle limit or on a PC self-loop. It sits beside the core in both simulation and FPGA builds, connected to its IF-stage PC and WB/MEM write ports.

## Interface
- ADDR_W, 32, PC and data-memory address width
- DATA_W, 32, register and memory data width
- DEPTH, 16, trace entries; power of two, minimum 4
- MAX_CYCLES, 600, cycles in RUN before termination; 1..65535
- STALL_LIMIT, 8, consecutive cycles with unchanged PC that count as a halt loop; minimum 2
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- pc_in  in  ADDR_W  core fetch PC
- rf_we  in  1  register-file write strobe
- rf_waddr  in  5  destination register
- rf_wdata  in  DATA_W  writeback data
- dm_we  in  1  data-memory write strobe
- dm_addr  in  ADDR_W  byte address
- dm_wdata  in  DATA_W  store data
- rd_valid  out  1  head entry available
- rd_ready  in  1  consumer accepts head entry
- rd_kind  out  2  01 RF write, 10 DM write, 11 end marker
- rd_cycle  out  16  cycle stamp of the entry
- rd_addr  out  ADDR_W  RF: zero-extended register number; DM: byte address; marker: last PC
- rd_data  out  DATA_W  write data; marker: {zeros, done_cause}
- cycle_count  out  16  cycles elapsed in RUN
- done  out  1  run terminated and buffer fully drained
- done_cause  out  2  01 cycle limit, 10 PC stall, 11 both in the same cycle
- overflow  out  1  sticky; at least one event dropped
- ovf_count  out  8  dropped events, saturating at 255

## Operation
- States: RUN, MARK, DRAIN, DONE. Reset enters RUN.
- RUN:
  - cycle_count increments every cycle.
  - An RF event is captured when rf_we=1 and rf_waddr!=0; writes to R0 are ignored.
  - A DM event is captured when dm_we=1.
  - When both occur in one cycle, push RF then DM, two pushes in that cycle. With one free slot, RF is stored and DM is dropped.
- Stall detection:
  - pc_in is registered each cycle. The stall counter increments when pc_in equals the registered value and clears otherwise.
  - Termination when the stall counter reaches STALL_LIMIT-1 or cycle_count equals MAX_CYCLES-1.
  - done_cause is latched and the FSM moves to MARK. Events in the terminating cycle are captured.
- MARK: push one end-marker entry as soon as a slot is free, then go to DRAIN. No events are captured in MARK, DRAIN or DONE, and cycle_count freezes.
- DRAIN: go to DONE when the buffer is empty.
- DONE: terminal state until reset.
- Buffer: circular, with read/write pointers one bit wider than log2(DEPTH) for full/empty.
  - Full: new events are dropped, overflow is set, and ovf_count increments by the number dropped (1 or 2).
  - Push and pop in the same cycle are both honoured, including when full.
- rd_* outputs show the head entry combinationally from the register array. When rd_valid=0, rd_* are don't-care.

## Timing
- Reset values: rd_valid 0, cycle_count 0, done 0, done_cause 0, overflow 0, ovf_count 0, all pointers 0.
- The first rising edge after rst deasserts is cycle 0. Each entry's stamp is the cycle_count value in its sampling cycle.
- Capture latency: an event sampled at edge N gives rd_valid=1 after edge N (usable in cycle N+1) if the buffer was empty.
- Handshake: pop on an edge where rd_valid && rd_ready. rd_* stay stable while rd_valid && !rd_ready. rd_ready is ignored when rd_valid=0.
- done rises on the edge that pops the final entry (the end marker).
- Asserting rst mid-run clears all state immediately, including the buffer contents' validity.

## Configuration
- TRACE_DM_EN defined:
  - DM writes are captured as kind 10.
  - Dual push is supported.
- TRACE_DM_EN undefined:
  - dm_* ports exist but are ignored.
  - Single push per cycle.
  - Kind 10 is never produced.

## Test plan
- Reset, then rf_we=1, rf_waddr=8, rf_wdata=0x5 in cycle 3, rd_ready=1 → one entry: kind 01, cycle 3, addr 8, data 5, popped the next cycle.
- rf_we with rf_waddr=0 in cycle 2 → no entry; rd_valid stays 0.
- With TRACE_DM_EN, RF write (R9, 0x11) and DM write (0x14, 0x22) in cycle 5, buffer empty → entries 01/9/0x11 then 10/0x14/0x22, both stamped 5. Without TRACE_DM_EN → only the RF entry.
- DEPTH=4, rd_ready=0, six RF writes in six cycles → 4 stored, overflow=1, ovf_count=2. Then rd_ready=1 → entries pop in order, stamps 0..3.
- MAX_CYCLES=20, PC incrementing by 4, rd_ready=1 → cycle_count freezes at 19 and the marker has cause 01 and cycle 19. done=1 after the marker pops, and done_cause=01.
- PC held at 0x40 from cycle 10, STALL_LIMIT=8 → termination in cycle 17 with cause 10 and marker addr 0x40. Asserting rst in cycle 12 of a repeated run → all outputs return to reset values and RUN restarts at cycle 0.
